// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Groups every signal between the datapath and the hazard controller.
//   slave modport  : seen by the controller (hazard inputs in, control out)
//   master modport : seen by the datapath / testbench (drives hazard inputs)
// Signals:
//   ihit, dhit, mem_req, ex_memread, ex_wsel, id_rs, id_rt, br_taken, cnt_clr
//       hazard sources and counter clear, datapath -> controller
//   pc_en, latch_en, latch_flush, hazard, stall_cnt, flush_cnt
//       pipeline control and performance counters, controller -> datapath
interface pipe_hazard_ctrl_if #(
    parameter int NSTAGES = 5,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16
);
    logic               ihit;
    logic               dhit;
    logic               mem_req;
    logic               ex_memread;
    logic [REG_W-1:0]   ex_wsel;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic               br_taken;
    logic               cnt_clr;

    logic               pc_en;
    logic [NSTAGES-2:0] latch_en;
    logic [NSTAGES-2:0] latch_flush;
    logic               hazard;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport slave (
        input  ihit, dhit, mem_req, ex_memread, ex_wsel, id_rs, id_rt,
               br_taken, cnt_clr,
        output pc_en, latch_en, latch_flush, hazard, stall_cnt, flush_cnt
    );

    modport master (
        output ihit, dhit, mem_req, ex_memread, ex_wsel, id_rs, id_rt,
               br_taken, cnt_clr,
        input  pc_en, latch_en, latch_flush, hazard, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush controller for an NSTAGES-deep in-order pipeline. Latch k sits
// between stage k and stage k+1. It generates the PC enable and per-latch
// enable/flush vectors from instruction-memory wait, data-memory wait,
// load-use and taken-branch conditions, and keeps saturating stall and flush
// counters.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (drains the pipeline while high)
//   bus  : pipe_hazard_ctrl_if.slave, hazard inputs and control outputs
module pipe_hazard_ctrl #(
    parameter int NSTAGES  = 5,
    parameter int BR_STAGE = 2,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    bus
);
    localparam int NL = NSTAGES - 1;
    // Latches upstream of the branch-resolving stage hold wrong-path work.
    localparam logic [NL-1:0]    BR_MASK = NL'((1 << BR_STAGE) - 1);
    localparam logic [NL-1:0]    ALL_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, FLUSH_PEND} state_t;

    state_t           state;
    logic [REG_W-1:0] ex_wsel;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             dwait;
    logic             lu;
    logic             fl;
    logic             pc_en;
    logic [NL-1:0]    latch_en;
    logic [NL-1:0]    latch_flush;
    logic             hazard;
    logic             flush_applied;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign ex_wsel = bus.ex_wsel;
    assign id_rs   = bus.id_rs;
    assign id_rt   = bus.id_rt;

    assign dwait = bus.mem_req & ~bus.dhit;
    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lu    = bus.ex_memread & (ex_wsel != '0) &
                   ((ex_wsel == id_rs) | (ex_wsel == id_rt));
    assign fl    = bus.br_taken | (state == FLUSH_PEND);

    // Priority-encoded pipeline control. Reset forces a full drain.
    always_comb begin
        pc_en       = 1'b1;
        latch_en    = ALL_ONES;
        latch_flush = '0;
        hazard      = dwait | fl | lu | ~bus.ihit;
        if (rst) begin
            pc_en       = 1'b0;
            latch_flush = ALL_ONES;
            hazard      = 1'b0;
        end else if (dwait) begin
            pc_en    = 1'b0;
            latch_en = '0;
        end else if (fl) begin
            latch_flush = BR_MASK;
        end else if (lu) begin
            // Hold IF/ID, push a bubble into ID/EX, let the load move on.
            pc_en          = 1'b0;
            latch_en[0]    = 1'b0;
            latch_flush[1] = 1'b1;
        end else if (!bus.ihit) begin
            pc_en          = 1'b0;
            latch_flush[0] = 1'b1;
        end
    end

    assign flush_applied = ~rst & ~dwait & fl;

    // A branch pulse that lands during a data wait would be lost, so it is
    // remembered here and replayed on the first cycle the wait clears.
    // Further pulses while pending collapse into the same single flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:        if (bus.br_taken && dwait) state <= FLUSH_PEND;
                FLUSH_PEND: if (!dwait) state <= RUN;
                default:    state <= RUN;
            endcase
        end
    end

    // Stall counter: cycles with the PC held, saturating, clear wins.
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            stall_q <= '0;
        end else if (!pc_en && stall_q != CNT_MAX) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    // Flush counter: applied flushes, saturating, clear wins.
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            flush_q <= '0;
        end else if (flush_applied && flush_q != CNT_MAX) begin
            flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.latch_en    = latch_en;
    assign bus.latch_flush = latch_flush;
    assign bus.hazard      = hazard;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed self-checking bench for pipe_hazard_ctrl (NSTAGES=5, BR_STAGE=2,
// CNT_W=4 so saturation is reachable quickly). Inputs change on the falling
// edge; combinational outputs are sampled 2 time units later.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    int   testCount;
    int   failCount;

    pipe_hazard_ctrl_if #(.NSTAGES(5), .REG_W(5), .CNT_W(4)) bus ();

    pipe_hazard_ctrl #(
        .NSTAGES(5), .BR_STAGE(2), .REG_W(5), .CNT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic setIdle();
        bus.ihit       = 1'b1;
        bus.dhit       = 1'b1;
        bus.mem_req    = 1'b0;
        bus.ex_memread = 1'b0;
        bus.ex_wsel    = '0;
        bus.id_rs      = '0;
        bus.id_rt      = '0;
        bus.br_taken   = 1'b0;
        bus.cnt_clr    = 1'b0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    // One idle cycle with cnt_clr, so both counters read 0 afterwards.
    task automatic clearCounters();
        setIdle();
        bus.cnt_clr = 1'b1;
        nextCycle();
        bus.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        setIdle();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            testCount++;
            if (bus.pc_en !== 1'b0 || bus.latch_en !== 4'b1111 ||
                bus.latch_flush !== 4'b1111 || bus.hazard !== 1'b0) begin
                $display("[TB] FAIL reset_outputs: got pc_en=%b en=%b flush=%b hz=%b required 0 1111 1111 0",
                         bus.pc_en, bus.latch_en, bus.latch_flush, bus.hazard);
                failCount++;
            end
            nextCycle();
        end
        testCount++;
        if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
            $display("[TB] FAIL reset_counters: got stall=%0d flush=%0d required 0 0",
                     bus.stall_cnt, bus.flush_cnt);
            failCount++;
        end
        rst = 1'b0;
        settle();
        testCount++;
        if (bus.pc_en !== 1'b1 || bus.latch_en !== 4'b1111 ||
            bus.latch_flush !== 4'b0000 || bus.hazard !== 1'b0) begin
            $display("[TB] FAIL post_reset_run: got pc_en=%b en=%b flush=%b hz=%b required 1 1111 0000 0",
                     bus.pc_en, bus.latch_en, bus.latch_flush, bus.hazard);
            failCount++;
        end
        nextCycle();
        settle();
        testCount++;
        if (bus.stall_cnt !== 4'd0) begin
            $display("[TB] FAIL post_reset_stall_cnt: got %0d required 0", bus.stall_cnt);
            failCount++;
        end
        nextCycle();
    endtask

    task automatic test_load_use();
        clearCounters();
        bus.ex_memread = 1'b1;
        bus.ex_wsel    = 5'd8;
        bus.id_rs      = 5'd3;
        bus.id_rt      = 5'd8;
        settle();
        testCount++;
        if (bus.pc_en !== 1'b0 || bus.latch_en !== 4'b1110 ||
            bus.latch_flush !== 4'b0010 || bus.hazard !== 1'b1) begin
            $display("[TB] FAIL load_use_rt: got pc_en=%b en=%b flush=%b hz=%b required 0 1110 0010 1",
                     bus.pc_en, bus.latch_en, bus.latch_flush, bus.hazard);
            failCount++;
        end
        nextCycle();
        bus.ex_wsel = 5'd9;
        bus.id_rs   = 5'd9;
        bus.id_rt   = 5'd4;
        settle();
        testCount++;
        if (bus.pc_en !== 1'b0 || bus.latch_en !== 4'b1110 ||
            bus.latch_flush !== 4'b0010) begin
            $display("[TB] FAIL load_use_rs: got pc_en=%b en=%b flush=%b required 0 1110 0010",
                     bus.pc_en, bus.latch_en, bus.latch_flush);
            failCount++;
        end
        nextCycle();
        bus.ex_wsel = 5'd0;
        bus.id_rs   = 5'd0;
        bus.id_rt   = 5'd0;
        settle();
        testCount++;
        if (bus.pc_en !== 1'b1 || bus.latch_en !== 4'b1111 ||
            bus.latch_flush !== 4'b0000 || bus.hazard !== 1'b0) begin
            $display("[TB] FAIL load_use_r0: got pc_en=%b en=%b flush=%b hz=%b required 1 1111 0000 0",
                     bus.pc_en, bus.latch_en, bus.latch_flush, bus.hazard);
            failCount++;
        end
        nextCycle();
        bus.ex_memread = 1'b0;
        bus.ex_wsel    = 5'd7;
        bus.id_rt      = 5'd7;
        settle();
        testCount++;
        if (bus.pc_en !== 1'b1 || bus.hazard !== 1'b0) begin
            $display("[TB] FAIL no_load_match: got pc_en=%b hz=%b required 1 0",
                     bus.pc_en, bus.hazard);
            failCount++;
        end
        testCount++;
        if (bus.stall_cnt !== 4'd2) begin
            $display("[TB] FAIL load_use_stall_cnt: got %0d required 2", bus.stall_cnt);
            failCount++;
        end
        nextCycle();
        setIdle();
    endtask

    task automatic test_branch();
        clearCounters();
        bus.br_taken = 1'b1;
        settle();
        testCount++;
        if (bus.pc_en !== 1'b1 || bus.latch_en !== 4'b1111 ||
            bus.latch_flush !== 4'b0011 || bus.hazard !== 1'b1) begin
            $display("[TB] FAIL branch_flush: got pc_en=%b en=%b flush=%b hz=%b required 1 1111 0011 1",
                     bus.pc_en, bus.latch_en, bus.latch_flush, bus.hazard);
            failCount++;
        end
        testCount++;
        if (bus.flush_cnt !== 4'd0) begin
            $display("[TB] FAIL branch_cnt_before: got %0d required 0", bus.flush_cnt);
            failCount++;
        end
        nextCycle();
        bus.br_taken = 1'b0;
        settle();
        testCount++;
        if (bus.flush_cnt !== 4'd1 || bus.latch_flush !== 4'b0000 || bus.hazard !== 1'b0) begin
            $display("[TB] FAIL branch_after: got cnt=%0d flush=%b hz=%b required 1 0000 0",
                     bus.flush_cnt, bus.latch_flush, bus.hazard);
            failCount++;
        end
        nextCycle();
        // Branch outranks load-use and an icache miss together.
        bus.br_taken   = 1'b1;
        bus.ex_memread = 1'b1;
        bus.ex_wsel    = 5'd12;
        bus.id_rs      = 5'd12;
        bus.ihit       = 1'b0;
        settle();
        testCount++;
        if (bus.pc_en !== 1'b1 || bus.latch_en !== 4'b1111 || bus.latch_flush !== 4'b0011) begin
            $display("[TB] FAIL branch_over_lu: got pc_en=%b en=%b flush=%b required 1 1111 0011",
                     bus.pc_en, bus.latch_en, bus.latch_flush);
            failCount++;
        end
        nextCycle();
        setIdle();
        settle();
        testCount++;
        if (bus.flush_cnt !== 4'd2 || bus.stall_cnt !== 4'd0) begin
            $display("[TB] FAIL branch_counts: got flush=%0d stall=%0d required 2 0",
                     bus.flush_cnt, bus.stall_cnt);
            failCount++;
        end
        nextCycle();
    endtask

    task automatic test_branch_dwait();
        clearCounters();
        bus.mem_req  = 1'b1;
        bus.dhit     = 1'b0;
        bus.br_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // A second pulse in the wait must be absorbed into the same flush.
            bus.br_taken = (i == 0 || i == 2);
            settle();
            testCount++;
            if (bus.pc_en !== 1'b0 || bus.latch_en !== 4'b0000 ||
                bus.latch_flush !== 4'b0000 || bus.hazard !== 1'b1) begin
                $display("[TB] FAIL dwait_freeze[%0d]: got pc_en=%b en=%b flush=%b hz=%b required 0 0000 0000 1",
                         i, bus.pc_en, bus.latch_en, bus.latch_flush, bus.hazard);
                failCount++;
            end
            nextCycle();
        end
        bus.br_taken = 1'b0;
        bus.dhit     = 1'b1;
        settle();
        testCount++;
        if (bus.pc_en !== 1'b1 || bus.latch_en !== 4'b1111 ||
            bus.latch_flush !== 4'b0011 || bus.hazard !== 1'b1) begin
            $display("[TB] FAIL pending_flush: got pc_en=%b en=%b flush=%b hz=%b required 1 1111 0011 1",
                     bus.pc_en, bus.latch_en, bus.latch_flush, bus.hazard);
            failCount++;
        end
        testCount++;
        if (bus.stall_cnt !== 4'd4 || bus.flush_cnt !== 4'd0) begin
            $display("[TB] FAIL dwait_counts: got stall=%0d flush=%0d required 4 0",
                     bus.stall_cnt, bus.flush_cnt);
            failCount++;
        end
        nextCycle();
        setIdle();
        settle();
        testCount++;
        if (bus.latch_flush !== 4'b0000 || bus.hazard !== 1'b0 ||
            bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd4) begin
            $display("[TB] FAIL back_to_run: got flush=%b hz=%b fcnt=%0d scnt=%0d required 0000 0 1 4",
                     bus.latch_flush, bus.hazard, bus.flush_cnt, bus.stall_cnt);
            failCount++;
        end
        nextCycle();
    endtask

    task automatic test_icache_miss();
        clearCounters();
        bus.ihit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            testCount++;
            if (bus.pc_en !== 1'b0 || bus.latch_en !== 4'b1111 ||
                bus.latch_flush !== 4'b0001 || bus.hazard !== 1'b1) begin
                $display("[TB] FAIL icache_miss[%0d]: got pc_en=%b en=%b flush=%b hz=%b required 0 1111 0001 1",
                         i, bus.pc_en, bus.latch_en, bus.latch_flush, bus.hazard);
                failCount++;
            end
            nextCycle();
        end
        // Data wait outranks the icache miss.
        bus.mem_req = 1'b1;
        bus.dhit    = 1'b0;
        settle();
        testCount++;
        if (bus.latch_en !== 4'b0000 || bus.latch_flush !== 4'b0000 || bus.stall_cnt !== 4'd2) begin
            $display("[TB] FAIL dwait_over_imiss: got en=%b flush=%b stall=%0d required 0000 0000 2",
                     bus.latch_en, bus.latch_flush, bus.stall_cnt);
            failCount++;
        end
        nextCycle();
        setIdle();
    endtask

    task automatic test_saturation();
        int expCnt;
        clearCounters();
        bus.ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            expCnt = (i > 15) ? 15 : i;
            settle();
            testCount++;
            if (bus.stall_cnt !== 4'(expCnt)) begin
                $display("[TB] FAIL stall_sat[%0d]: got %0d required %0d", i, bus.stall_cnt, expCnt);
                failCount++;
            end
            nextCycle();
        end
        setIdle();
        bus.cnt_clr = 1'b1;
        settle();
        testCount++;
        if (bus.stall_cnt !== 4'd15) begin
            $display("[TB] FAIL stall_held: got %0d required 15", bus.stall_cnt);
            failCount++;
        end
        nextCycle();
        bus.cnt_clr = 1'b0;
        settle();
        testCount++;
        if (bus.stall_cnt !== 4'd0) begin
            $display("[TB] FAIL cnt_clr: got %0d required 0", bus.stall_cnt);
            failCount++;
        end
        nextCycle();
    endtask

    task automatic test_reset_pending();
        setIdle();
        bus.mem_req  = 1'b1;
        bus.dhit     = 1'b0;
        bus.br_taken = 1'b1;
        nextCycle();
        bus.br_taken = 1'b0;
        rst          = 1'b1;
        nextCycle();
        rst = 1'b0;
        setIdle();
        settle();
        testCount++;
        if (bus.latch_flush !== 4'b0000 || bus.hazard !== 1'b0 || bus.pc_en !== 1'b1) begin
            $display("[TB] FAIL reset_drops_pending: got flush=%b hz=%b pc_en=%b required 0000 0 1",
                     bus.latch_flush, bus.hazard, bus.pc_en);
            failCount++;
        end
        nextCycle();
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst       = 1'b1;
        setIdle();
        test_reset();
        test_load_use();
        test_branch();
        test_branch_dwait();
        test_icache_miss();
        test_saturation();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
